if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
// - Instruction-fetch stage of the pipelined MIPS-Lite CPU; the consumer of the PC register's dataOut.
// - Issues word reads to instruction memory at the current PC and pulses pc_advance so next-PC logic loads PC+4.
// - Buffers in-order responses with their PC tags in a prefetch FIFO, presents them to the IF/ID boundary, and handles stall/flush.
// PARAMETERS
// - DEPTH     2   prefetch FIFO entries; also caps requests in flight (power of 2, >=2)
// - RESET_PC  0   PC tag reported while no valid PC has been sampled (diagnostic only)
// PORTS
// - clk           in   1   rising-edge clock, sole clock
// - rst_n         in   1   synchronous active-low reset
// - pc_in         in   32  current PC (PC register dataOut)
// - pc_advance    out  1   1-cycle pulse: request accepted, PC may advance
// - imem_req_vld  out  1   read request valid
// - imem_req_addr out  32  read address = pc_in, word aligned
// - imem_req_rdy  in   1   memory accepts request
// - imem_rsp_vld  in   1   read data valid, in request order, >=1 cycle after accept
// - imem_rsp_data in   32  instruction word
// - id_stall      in   1   ID cannot accept this cycle
// - flush         in   1   branch/jump taken: discard all fetched and in-flight instructions
// - if_valid      out  1   IF/ID entry valid
// - if_instr      out  32  instruction
// - if_pc         out  32  PC of instruction
// - if_pc4        out  32  if_pc + 4 (mod 2^32)
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): FIFO empty, inflight=0, drop=0, state=FETCH; all outputs 0 (if_pc=RESET_PC) the following cycle.
// - State FETCH: imem_req_vld = !flush && (inflight + fifo_count < DEPTH) (combinational). Accept = vld && rdy -> pc_advance=1 same cycle, inflight++.
// - Response: data+tag written to FIFO tail when drop==0; inflight--. Tag queue holds issued addresses, popped with response.
// - Output: if_valid = FIFO non-empty; if_* from FIFO head; pop when if_valid && !id_stall. Zero-cycle path response->ID not allowed: min IF latency = 1 cycle after rsp.
// - Simultaneous push and pop on full FIFO: legal (credit check guarantees no overflow); count unchanged.
// - flush=1: same-cycle no request, no pc_advance; next cycle FIFO empty, if_valid=0; drop <= inflight (minus any response arriving this cycle); state -> DRAIN if result nonzero else FETCH.
// - State DRAIN: no requests; each response decrements drop and inflight, data discarded; when drop reaches 0 -> FETCH, request at new pc_in next cycle.
// - flush during DRAIN: drop recomputed from inflight; stays DRAIN.
// - flush and id_stall together: flush wins.
// - Address wrap: pc_in=0xFFFF_FFFC gives if_pc4=0x0000_0000; no fault.
// - Misaligned pc_in (bits[1:0]!=0): address forced to pc_in&~3, tag keeps pc_in.
// - rsp with inflight==0: ignored (protocol error, assertion in sim).
// - Reset mid-operation: in-flight responses after reset are ignored by the inflight==0 rule; memory must also be reset.
// CONFIGURATION
// - IF_PERF_CNT_EN defined: adds outputs perf_fetch[31:0] (accepted requests) and perf_stall[31:0] (cycles if_valid && id_stall); both cleared by rst_n, wrap at 2^32, not cleared by flush.
// - IF_PERF_CNT_EN undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
// - Reset then pc_in=0, rdy=1, 1-cycle rsp 0x2001_0001 -> pc_advance cycle 1, if_valid=1 with if_pc=0, if_pc4=4 two cycles after accept.
// - Stream pc 0,4,8,C with id_stall=1 held -> exactly DEPTH=2 requests issued, then imem_req_vld=0 until stall drops; order 0,4,8,C preserved.
// - flush with 2 in flight, rsp 0xAAAA/0xBBBB arriving later -> both discarded, if_valid stays 0, next request at new pc_in=0x40 after second rsp.
// - imem_req_rdy=0 for 5 cycles -> no pc_advance, req_addr stable at pc_in, no FIFO change.
// - pc_in=0xFFFF_FFFC -> if_pc4=0x0000_0000; pc_in=0x6 -> req_addr=0x4, if_pc=0x6.
// - IF_PERF_CNT_EN: 3 fetches, 4 stall cycles -> perf_fetch=3, perf_stall=4; rst_n=0 -> both 0.

Source files
------------

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - MIPS-Lite instruction fetch stage with PC-tagged prefetch FIFO.
// Optional IF_PERF_CNT_EN adds perf_fetch/perf_stall counters.
module if_fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  output logic        pc_advance,
  output logic        imem_req_vld,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_rdy,
  input  logic        imem_rsp_vld,
  input  logic [31:0] imem_rsp_data,
  input  logic        id_stall,
  input  logic        flush,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic {FETCH, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] tag_wr_q, tag_rd_q;
  logic [AW-1:0] fifo_wr_q, fifo_rd_q;
  logic [31:0]   tag_mem_q   [DEPTH];
  logic [31:0]   fifo_instr_q[DEPTH];
  logic [31:0]   fifo_pc_q   [DEPTH];

  logic [CW:0] credit_used;
  logic        rsp_ok;
  logic        req_ok;
  logic        accept;
  logic        push;
  logic        pop;

  // Credits cover both in-flight reads and buffered words, so a push can never overflow.
  assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};
  assign rsp_ok      = imem_rsp_vld && (inflight_q != '0);
  assign req_ok      = rst_n && (state_q == FETCH) && !flush && (credit_used < DEPTH_C);
  assign accept      = req_ok && imem_req_rdy;
  assign push        = rsp_ok && (drop_q == '0) && !flush;
  assign pop         = if_valid && !id_stall && !flush;

  assign imem_req_vld  = req_ok;
  assign imem_req_addr = {pc_in[31:2], 2'b00};
  assign pc_advance    = accept;

  assign if_valid = (count_q != '0);
  assign if_instr = if_valid ? fifo_instr_q[fifo_rd_q] : 32'h0;
  assign if_pc    = if_valid ? fifo_pc_q[fifo_rd_q] : RESET_PC;
  assign if_pc4   = if_valid ? (fifo_pc_q[fifo_rd_q] + 32'd4) : 32'h0;

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + CW'(accept) - CW'(rsp_ok);
    count_d    = count_q + CW'(push) - CW'(pop);
    if (flush) begin
      count_d = '0;
      drop_d  = inflight_q - CW'(rsp_ok);
      state_d = (drop_d != '0) ? DRAIN : FETCH;
    end else begin
      case (state_q)
        FETCH: state_d = FETCH;
        DRAIN: begin
          if (rsp_ok) begin
            drop_d = drop_q - CW'(1);
            if (drop_d == '0) state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      if (accept) tag_wr_q <= tag_wr_q + AW'(1);
      if (rsp_ok) tag_rd_q <= tag_rd_q + AW'(1);
      if (flush) begin
        fifo_wr_q <= '0;
        fifo_rd_q <= '0;
      end else begin
        if (push) fifo_wr_q <= fifo_wr_q + AW'(1);
        if (pop)  fifo_rd_q <= fifo_rd_q + AW'(1);
      end
    end
  end

  // Tag keeps the raw pc_in, so a misaligned PC is reported as issued.
  always_ff @(posedge clk) begin
    if (accept) tag_mem_q[tag_wr_q] <= pc_in;
    if (push) begin
      fifo_instr_q[fifo_wr_q] <= imem_rsp_data;
      fifo_pc_q[fifo_wr_q]    <= tag_mem_q[tag_rd_q];
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (accept) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (if_valid && id_stall) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_stall = perf_stall_q;
`endif

  rsp_without_request: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_vld |-> (inflight_q != '0));

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - Self-checking bench for if_fetch_unit against an in-order fetch reference model.
module tb_if_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        pc_advance;
  logic        imem_req_vld;
  logic [31:0] imem_req_addr;
  logic        imem_req_rdy;
  logic        imem_rsp_vld;
  logic [31:0] imem_rsp_data;
  logic        id_stall;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
`endif

  if_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_advance(pc_advance),
    .imem_req_vld(imem_req_vld), .imem_req_addr(imem_req_addr), .imem_req_rdy(imem_req_rdy),
    .imem_rsp_vld(imem_rsp_vld), .imem_rsp_data(imem_rsp_data),
    .id_stall(id_stall), .flush(flush),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch(perf_fetch), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; int rdy_cyc; } exp_t;
  typedef struct { logic [31:0] addr; bit stale; int acc_cyc; } mem_t;

  exp_t        exp_q[$];
  mem_t        mem_q[$];
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          n_acc_r = 0;
  int          n_stl_r = 0;
  int          stale_out = 0;
  int          mem_rate = 100;
  bit          saw_acc = 0;
  bit          saw_flush = 0;
  bit          rsp_stale_now = 0;
  logic [31:0] flush_target = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_0001;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    bit   acc, pop, front_ok, exp_vld;
    exp_t e;
    if (!rst_n) begin
      chk("rst_req_vld", imem_req_vld, 0);
      exp_q.delete(); mem_q.delete();
      stale_out = 0; n_acc_r = 0; n_stl_r = 0;
      saw_acc = 0; saw_flush = 0;
      return;
    end
    acc      = imem_req_vld && imem_req_rdy;
    pop      = if_valid && !id_stall && !flush;
    exp_vld  = !flush && (stale_out == 0) && (exp_q.size() < DEPTH);
    front_ok = (exp_q.size() > 0) && (exp_q[0].rdy_cyc >= 0) && (exp_q[0].rdy_cyc < cyc);
    chk("req_vld", imem_req_vld, exp_vld);
    chk("pc_advance", pc_advance, acc);
    chk("req_addr", imem_req_addr, pc_in & 32'hFFFF_FFFC);
    chk("if_valid", if_valid, front_ok);
    if (if_valid && front_ok) begin
      chk("if_pc", if_pc, exp_q[0].pc);
      chk("if_instr", if_instr, exp_q[0].instr);
      chk("if_pc4", if_pc4, exp_q[0].pc + 32'd4);
    end
    if (if_valid && id_stall) n_stl_r++;
    if (imem_rsp_vld) begin
      if (rsp_stale_now) stale_out--;
      else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          if (exp_q[i].rdy_cyc < 0) begin
            e = exp_q[i]; e.rdy_cyc = cyc; exp_q[i] = e;
            break;
          end
        end
      end
    end
    if (pop && front_ok) begin
      pop_log.push_back(exp_q[0].pc);
      void'(exp_q.pop_front());
    end
    if (acc) begin
      exp_q.push_back('{pc: pc_in, instr: mem_word(pc_in & 32'hFFFF_FFFC), rdy_cyc: -1});
      mem_q.push_back('{addr: pc_in & 32'hFFFF_FFFC, stale: 1'b0, acc_cyc: cyc});
      acc_log.push_back(pc_in);
      n_acc++; n_acc_r++;
    end
    if (flush) begin
      for (int i = 0; i < mem_q.size(); i++) begin
        mem_t m;
        m = mem_q[i]; m.stale = 1'b1; mem_q[i] = m;
      end
      stale_out = mem_q.size();
      exp_q.delete();
    end
    saw_acc = acc;
    saw_flush = flush;
  endtask

  task automatic drive();
    mem_t m;
    cyc++;
    if (saw_acc) pc_in = pc_in + 32'd4;
    if (saw_flush) pc_in = flush_target;
    imem_rsp_vld = 1'b0;
    imem_rsp_data = 32'h0;
    rsp_stale_now = 1'b0;
    if (rst_n && mem_q.size() > 0 && mem_q[0].acc_cyc < cyc && $urandom_range(0, 99) < mem_rate) begin
      m = mem_q.pop_front();
      imem_rsp_vld = 1'b1;
      imem_rsp_data = mem_word(m.addr);
      rsp_stale_now = m.stale;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic go_idle();
    int n = 0;
    imem_req_rdy = 1'b0; flush = 1'b0; id_stall = 1'b0; mem_rate = 100;
    while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 50) begin
      cycle(); n++;
    end
    chk("idle_timeout", 32'(n < 50), 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!if_valid && n < 20) begin
      cycle(); n++;
    end
    chk("valid_timeout", 32'(n < 20), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base;
    rst_n = 1'b0; pc_in = 32'h0; imem_req_rdy = 1'b0; imem_rsp_vld = 1'b0;
    imem_rsp_data = 32'h0; id_stall = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    repeat (3) cycle();
    #1;
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_instr", if_instr, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_pc4", if_pc4, 0);
    chk("rst_pc_advance", pc_advance, 0);

    // first fetch: accept in cycle 1, visible two cycles later
    rst_n = 1'b1; imem_req_rdy = 1'b1; pc_in = 32'h0; mem_rate = 100;
    #1;
    chk("t1_pc_advance", pc_advance, 1);
    chk("t1_req_addr", imem_req_addr, 32'h0);
    cycle(); #1;
    chk("t1_not_yet_valid", if_valid, 0);
    cycle(); #1;
    chk("t1_valid", if_valid, 1);
    chk("t1_if_pc", if_pc, 32'h0);
    chk("t1_if_pc4", if_pc4, 32'h4);
    chk("t1_if_instr", if_instr, 32'h2001_0001);

    // held stall caps requests at DEPTH, order preserved afterwards
    go_idle();
    pc_in = 32'h0; id_stall = 1'b1; imem_req_rdy = 1'b1;
    acc_log.delete(); pop_log.delete();
    base = n_acc;
    repeat (8) cycle();
    #1;
    chk("stall_req_count", 32'(n_acc - base), DEPTH);
    chk("stall_req_vld", imem_req_vld, 0);
    id_stall = 1'b0;
    repeat (12) cycle();
    for (int i = 0; i < 4; i++) chk("stall_order", (pop_log.size() > i) ? pop_log[i] : 32'hDEAD_BEEF, 32'(4 * i));

    // flush with two reads in flight
    go_idle();
    pc_in = 32'h20; mem_rate = 0; imem_req_rdy = 1'b1;
    base = n_acc;
    for (int n = 0; n < 10 && (n_acc - base) < 2; n++) cycle();
    chk("flush_setup", 32'(n_acc - base), 2);
    flush = 1'b1; flush_target = 32'h40;
    cycle();
    flush = 1'b0;
    #1;
    chk("flush_if_valid", if_valid, 0);
    chk("flush_drain_vld", imem_req_vld, 0);
    repeat (3) begin
      cycle(); #1;
      chk("drain_no_req", imem_req_vld, 0);
    end
    acc_log.delete();
    mem_rate = 100;
    repeat (6) cycle();
    chk("flush_next_addr", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, 32'h40);

    // memory not ready
    go_idle();
    pc_in = 32'h100;
    repeat (5) begin
      #1;
      chk("nrdy_pc_advance", pc_advance, 0);
      chk("nrdy_req_addr", imem_req_addr, 32'h100);
      chk("nrdy_if_valid", if_valid, 0);
      cycle();
    end

    // address wrap
    go_idle();
    pc_in = 32'hFFFF_FFFC; imem_req_rdy = 1'b1;
    cycle();
    imem_req_rdy = 1'b0;
    wait_valid();
    chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_if_pc4", if_pc4, 32'h0);

    // misaligned PC
    go_idle();
    pc_in = 32'h6; imem_req_rdy = 1'b1;
    #1;
    chk("mis_req_addr", imem_req_addr, 32'h4);
    cycle();
    imem_req_rdy = 1'b0;
    wait_valid();
    chk("mis_if_pc", if_pc, 32'h6);
    chk("mis_if_pc4", if_pc4, 32'hA);
    chk("mis_if_instr", if_instr, mem_word(32'h4));

    // randomized traffic with flushes and one mid-run reset
    mem_rate = 60;
    for (int i = 0; i < 2500; i++) begin
      rst_n = !(i == 1200 || i == 1201);
      imem_req_rdy = ($urandom_range(0, 99) < 70);
      id_stall = ($urandom_range(0, 99) < 30);
      flush = ($urandom_range(0, 99) < 4);
      if (flush) begin
        flush_target = $urandom & 32'h0000_0FFC;
        if ($urandom_range(0, 7) == 0) flush_target = flush_target | 32'h2;
        if ($urandom_range(0, 15) == 0) flush_target = 32'hFFFF_FFF8;
      end
      cycle();
    end
    go_idle();

`ifdef IF_PERF_CNT_EN
    #1;
    chk("perf_fetch", perf_fetch, 32'(n_acc_r));
    chk("perf_stall", perf_stall, 32'(n_stl_r));
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    #1;
    chk("perf_fetch_rst", perf_fetch, 0);
    chk("perf_stall_rst", perf_stall, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
